// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM responder: pin width, monitor states and error bit map.
package sram_pkg;
  localparam int SRAM_ADDR_W  = 19;
  localparam int ERR_W        = 4;
  localparam int ERR_OE_WE    = 0;
  localparam int ERR_WE_LONG  = 1;
  localparam int ERR_UNSTABLE = 2;
  localparam int ERR_RANGE    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } mon_state_t;
endpackage

// File: rtl/sram_array.sv
// DATA_W x 2**ADDR_W storage: synchronous write, asynchronous read.
module sram_array #(
  parameter int    ADDR_W    = 10,
  parameter int    DATA_W    = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// Chip-side stand-in for the external async SRAM, with a pin-protocol monitor.
//   state | meaning
//   IDLE  | no access in progress
//   RD    | cs and oe low, we high: read access open
//   WR    | cs and we low: write pulse open, address/data latched on entry
module sram_responder
  import sram_pkg::*;
#(
  parameter int    ADDR_W    = 10,
  parameter int    DATA_W    = 16,
  parameter int    MAX_WE    = 4,
  parameter string INIT_FILE = ""
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SRAM_ADDR_W-1:0] rama,
  input  logic [DATA_W-1:0]      ramd_in,
  output logic [DATA_W-1:0]      ramd_out,
  output logic                   ramd_oe,
  input  logic                   ramcs,
  input  logic                   ramoe,
  input  logic                   ramwe,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count,
  output logic [ERR_W-1:0]       err,
  input  logic                   err_clr
);

  localparam int WE_CNT_W = $clog2(MAX_WE + 2);
  localparam logic [WE_CNT_W-1:0] WE_LIMIT = WE_CNT_W'(MAX_WE);
  localparam logic [WE_CNT_W-1:0] WE_SAT   = WE_CNT_W'(MAX_WE + 1);

  mon_state_t            state, state_nx;
  logic                  rd_pins, wr_pins, in_range, mem_we;
  logic                  rd_inc, wr_inc, wr_enter;
  logic [ERR_W-1:0]      err_new;
  logic [WE_CNT_W-1:0]   we_len;
  logic [SRAM_ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0]     lat_data;
  logic [DATA_W-1:0]     rdata;

  assign rd_pins  = ~ramcs & ~ramoe & ramwe;
  assign wr_pins  = ~ramcs & ~ramwe;
  assign in_range = (rama[SRAM_ADDR_W-1:ADDR_W] == '0);
  assign mem_we   = wr_pins & in_range & ~reset;

  sram_array #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .addr  (rama[ADDR_W-1:0]),
    .wdata (ramd_in),
    .rdata (rdata)
  );

  assign ramd_oe  = rd_pins & ~reset;
  assign ramd_out = (ramd_oe && in_range) ? rdata : '0;

  always_comb begin
    state_nx = state;
    rd_inc   = 1'b0;
    wr_inc   = 1'b0;
    wr_enter = 1'b0;
    err_new  = '0;
    err_new[ERR_OE_WE] = ~ramcs & ~ramoe & ~ramwe;
    err_new[ERR_RANGE] = ~ramcs & (~ramwe | ~ramoe) & ~in_range;
    case (state)
      IDLE: begin
        if (rd_pins) begin
          state_nx = RD;
        end else if (wr_pins) begin
          state_nx = WR;
          wr_enter = 1'b1;
        end
      end
      RD: begin
        if (ramcs | ramoe) begin
          state_nx = IDLE;
          rd_inc   = 1'b1;
        end else if (~ramwe) begin
          state_nx = WR;
          wr_enter = 1'b1;
          err_new[ERR_OE_WE] = 1'b1;
        end
      end
      WR: begin
        if (ramwe | ramcs) begin
          state_nx = IDLE;
          wr_inc   = 1'b1;
        end else begin
          // we_len counts the cycles already seen low, so this cycle makes it we_len+1
          if (we_len >= WE_LIMIT) err_new[ERR_WE_LONG] = 1'b1;
          if ((rama != lat_addr) || (ramd_in != lat_data)) err_new[ERR_UNSTABLE] = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_count <= '0;
      wr_count <= '0;
      err      <= '0;
      we_len   <= '0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      state <= state_nx;
      if (rd_inc) rd_count <= rd_count + 16'd1;
      if (wr_inc) wr_count <= wr_count + 16'd1;
      if (wr_enter) begin
        lat_addr <= rama;
        lat_data <= ramd_in;
        we_len   <= WE_CNT_W'(1);
      end else if (state == WR && we_len != WE_SAT) begin
        we_len <= we_len + WE_CNT_W'(1);
      end
      err <= (err_clr ? '0 : err) | err_new;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized pin run.
module tb_sram_responder;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [18:0] rama;
  logic [15:0] ramd_in;
  logic [15:0] ramd_out;
  logic        ramd_oe;
  logic        ramcs, ramoe, ramwe;
  logic [15:0] rd_count, wr_count;
  logic [3:0]  err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model: memory contents, access bookkeeping and counters.
  logic [15:0] mem_m [1024];
  bit          vld   [1024];
  int          acc;            // 0 none, 1 read open, 2 write open
  int          we_low;
  logic [18:0] lat_a;
  logic [15:0] lat_d;
  int          rdc, wrc;
  logic [3:0]  errm;

  sram_responder dut (
    .clock    (clock),
    .reset    (reset),
    .rama     (rama),
    .ramd_in  (ramd_in),
    .ramd_out (ramd_out),
    .ramd_oe  (ramd_oe),
    .ramcs    (ramcs),
    .ramoe    (ramoe),
    .ramwe    (ramwe),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    acc = 0; we_low = 0; rdc = 0; wrc = 0; errm = '0;
  endtask

  task automatic model_step();
    logic [3:0] ne;
    logic       oor;
    int         ai;
    ne  = '0;
    oor = (rama[18:10] != 0);
    ai  = int'(rama[9:0]);
    if (!ramcs && !ramoe && !ramwe) ne[0] = 1'b1;
    if (!ramcs && (!ramwe || !ramoe) && oor) ne[3] = 1'b1;
    if (!ramcs && !ramwe && !oor) begin
      mem_m[ai] = ramd_in;
      vld[ai]   = 1'b1;
    end
    if (acc == 0) begin
      if (!ramcs && !ramoe && ramwe) acc = 1;
      else if (!ramcs && !ramwe) begin acc = 2; we_low = 1; lat_a = rama; lat_d = ramd_in; end
    end else if (acc == 1) begin
      if (ramcs || ramoe) begin acc = 0; rdc = (rdc + 1) % 65536; end
      else if (!ramwe) begin acc = 2; we_low = 1; lat_a = rama; lat_d = ramd_in; ne[0] = 1'b1; end
    end else begin
      if (ramwe || ramcs) begin acc = 0; wrc = (wrc + 1) % 65536; end
      else begin
        we_low++;
        if (we_low > 4) ne[1] = 1'b1;
        if (rama != lat_a || ramd_in != lat_d) ne[2] = 1'b1;
      end
    end
    errm = (err_clr ? 4'b0 : errm) | ne;
  endtask

  task automatic set_pins(input logic c, input logic o, input logic w,
                          input logic [18:0] a, input logic [15:0] d, input logic cl);
    ramcs = c; ramoe = o; ramwe = w; rama = a; ramd_in = d; err_clr = cl;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic c, input logic o, input logic w,
                     input logic [18:0] a, input logic [15:0] d, input logic cl);
    set_pins(c, o, w, a, d, cl);
    tick();
  endtask

  task automatic idle(input logic cl);
    cyc(1'b1, 1'b1, 1'b1, rama, ramd_in, cl);
  endtask

  task automatic do_reset();
    set_pins(1'b1, 1'b1, 1'b1, 19'd0, 16'd0, 1'b0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin : compare
    logic exp_oe;
    if (chk_en) begin
      exp_oe = !reset && !ramcs && !ramoe && ramwe;
      check("ramd_oe", 32'(ramd_oe), 32'(exp_oe));
      if (!exp_oe || rama[18:10] != 0) check("ramd_out_zero", 32'(ramd_out), 32'd0);
      else if (vld[int'(rama[9:0])]) check("ramd_out", 32'(ramd_out), 32'(mem_m[int'(rama[9:0])]));
      check("rd_count", 32'(rd_count), 32'(rdc));
      check("wr_count", 32'(wr_count), 32'(wrc));
      check("err", 32'(err), 32'(errm));
    end
  end

  initial begin
    logic [15:0] q;
    do_reset();
    chk_en = 1;
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ramd_oe", 32'(ramd_oe), 32'd0);
    check("rst_ramd_out", 32'(ramd_out), 32'd0);

    // 0x005 <- 1234, then zero-latency read
    cyc(1'b0, 1'b1, 1'b0, 19'h005, 16'h1234, 1'b0);
    idle(1'b0);
    check("w5_wr_count", 32'(wr_count), 32'd1);
    set_pins(1'b0, 1'b0, 1'b1, 19'h005, 16'h0, 1'b0);
    #1;
    check("r5_same_cycle_oe", 32'(ramd_oe), 32'd1);
    check("r5_same_cycle_data", 32'(ramd_out), 32'h1234);
    tick();
    idle(1'b0);
    check("r5_rd_count", 32'(rd_count), 32'd1);

    // controller-style write then read of 0x3FF
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 19'h3FF, 16'hBEEF, 1'b0);
    idle(1'b0);
    set_pins(1'b0, 1'b0, 1'b1, 19'h3FF, 16'h0, 1'b0);
    @(negedge clock);
    q = ramd_out;
    tick();
    idle(1'b0);
    check("ctrl_q", 32'(q), 32'hBEEF);
    check("ctrl_wr_count", 32'(wr_count), 32'd1);
    check("ctrl_rd_count", 32'(rd_count), 32'd1);
    check("ctrl_err", 32'(err), 32'd0);

    // oe and we both low
    set_pins(1'b0, 1'b0, 1'b0, 19'h010, 16'h0F0F, 1'b0);
    #1;
    check("oewe_ramd_oe", 32'(ramd_oe), 32'd0);
    tick();
    idle(1'b0);
    check("oewe_err", 32'(err), 32'h1);
    idle(1'b1);
    check("oewe_clr", 32'(err), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 19'h010, 16'h0F0F, 1'b1);
    check("clr_vs_new_err", 32'(err), 32'h1);
    idle(1'b1);

    // we held low for six cycles
    do_reset();
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 19'h030, 16'h1111, 1'b0);
    check("we4_err", 32'(err), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 19'h030, 16'h1111, 1'b0);
    check("we5_err", 32'(err), 32'h2);
    cyc(1'b0, 1'b1, 1'b0, 19'h030, 16'h1111, 1'b0);
    idle(1'b0);
    check("we6_wr_count", 32'(wr_count), 32'd1);

    // out-of-range write is dropped
    idle(1'b1);
    cyc(1'b0, 1'b1, 1'b0, 19'h000, 16'hA5A5, 1'b0);
    idle(1'b0);
    cyc(1'b0, 1'b1, 1'b0, 19'h00400, 16'h5555, 1'b0);
    check("oor_err", 32'(err), 32'h8);
    idle(1'b0);
    set_pins(1'b0, 1'b0, 1'b1, 19'h000, 16'h0, 1'b0);
    #1;
    check("oor_read0", 32'(ramd_out), 32'hA5A5);
    tick();
    idle(1'b0);
    set_pins(1'b0, 1'b0, 1'b1, 19'h00400, 16'h0, 1'b0);
    #1;
    check("oor_read_out", 32'(ramd_out), 32'h0);
    tick();
    idle(1'b1);

    // reset while a write is open
    cyc(1'b0, 1'b1, 1'b0, 19'h020, 16'h7777, 1'b0);
    idle(1'b0);
    cyc(1'b0, 1'b1, 1'b0, 19'h021, 16'h2222, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 19'h021, 16'h2222, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    set_pins(1'b0, 1'b0, 1'b1, 19'h020, 16'h0, 1'b0);
    #1;
    check("rstwr_ramd_oe", 32'(ramd_oe), 32'd0);
    check("rstwr_wr_count", 32'(wr_count), 32'd0);
    check("rstwr_rd_count", 32'(rd_count), 32'd0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("rstwr_data_kept", 32'(ramd_out), 32'h7777);
    cyc(1'b0, 1'b0, 1'b1, 19'h020, 16'h0, 1'b0);
    idle(1'b0);
    check("rstwr_rd_after", 32'(rd_count), 32'd1);
    check("rstwr_wr_after", 32'(wr_count), 32'd0);

    // randomized pin activity
    idle(1'b1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ramcs = ($urandom_range(0, 3) == 0);
        ramoe = 1'($urandom_range(0, 1));
        ramwe = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 15) == 0)
          rama = {9'($urandom_range(1, 511)), 10'($urandom_range(0, 15) * 67)};
        else
          rama = {9'd0, 10'($urandom_range(0, 15) * 67)};
        ramd_in = 16'($urandom);
      end
      err_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle(1'b0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
